// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: field widths, load/store size encoding,
// FSM state encoding, the captured-op record and small size helpers.
package mem_stage_pkg;

    localparam int LREG_W   = 5;
    localparam int RESULT_W = 64;
    localparam int PC_W     = 64;
    localparam int INSTR_W  = 32;

    // One-hot access size, msb..lsb = {dword, word, half, byte}
    localparam logic [3:0] LS_BYTE  = 4'b0001;
    localparam logic [3:0] LS_HALF  = 4'b0010;
    localparam logic [3:0] LS_WORD  = 4'b0100;
    localparam logic [3:0] LS_DWORD = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Memory op held while the data-memory transaction is outstanding
    typedef struct packed {
        logic [LREG_W-1:0]   rd;
        logic                need_to_wb;
        logic                is_store;
        logic                is_unsigned;
        logic [3:0]          ls_size;
        logic [RESULT_W-1:0] addr;
        logic [RESULT_W-1:0] store_data;
        logic [PC_W-1:0]     pc;
        logic [INSTR_W-1:0]  instr;
    } mem_op_t;

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_mask(input logic [3:0] ls_size);
        case (ls_size)
            LS_BYTE: align_mask = 3'b000;
            LS_HALF: align_mask = 3'b001;
            LS_WORD: align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    // Byte-enable pattern for the access size, before lane shifting
    function automatic logic [7:0] byte_mask(input logic [3:0] ls_size);
        case (ls_size)
            LS_BYTE: byte_mask = 8'h01;
            LS_HALF: byte_mask = 8'h03;
            LS_WORD: byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: moves the addressed bytes of a 64-bit read beat down to
// bit 0, truncates to the access size and zero- or sign-extends to 64 bits.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [RESULT_W-1:0] rdata,
    input  logic [2:0]          offset,
    input  logic [3:0]          ls_size,
    input  logic                is_unsigned,
    output logic [RESULT_W-1:0] data
);

    logic [RESULT_W-1:0] shifted;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (ls_size)
            LS_BYTE: data = is_unsigned ? {56'b0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            LS_HALF: data = is_unsigned ? {48'b0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            LS_WORD: data = is_unsigned ? {32'b0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: completes ALU/branch/muldiv ops directly and runs aligned loads and
// stores through a single-outstanding data-memory request/response interface.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,

    input  logic                ex_valid,
    input  logic [LREG_W-1:0]   ex_rd,
    input  logic                ex_need_to_wb,
    input  logic                ex_is_load,
    input  logic                ex_is_store,
    input  logic [3:0]          ex_ls_size,
    input  logic                ex_is_unsigned,
    input  logic                ex_is_bju,
    input  logic                ex_is_muldiv,
    input  logic [RESULT_W-1:0] ex_ls_address,
    input  logic [RESULT_W-1:0] ex_store_data,
    input  logic [RESULT_W-1:0] ex_alu_result,
    input  logic [RESULT_W-1:0] ex_bju_result,
    input  logic [RESULT_W-1:0] ex_muldiv_result,
    input  logic [PC_W-1:0]     ex_pc,
    input  logic [INSTR_W-1:0]  ex_instr,
    output logic                ex_ready,

    input  logic                flush,

    output logic                dmem_req_valid,
    output logic                dmem_req_wen,
    output logic [RESULT_W-1:0] dmem_req_addr,
    output logic [RESULT_W-1:0] dmem_req_wdata,
    output logic [7:0]          dmem_req_wmask,
    input  logic                dmem_req_ready,
    input  logic                dmem_resp_valid,
    input  logic [RESULT_W-1:0] dmem_resp_rdata,

    output logic                wb_valid,
    output logic [LREG_W-1:0]   wb_rd,
    output logic                wb_wen,
    output logic [RESULT_W-1:0] wb_data,
    output logic [PC_W-1:0]     wb_pc,
    output logic [INSTR_W-1:0]  wb_instr,
    output logic                wb_misalign
);

    state_t              state;
    state_t              state_next;
    mem_op_t             op;
    logic                killed;

    logic                accept;
    logic                is_mem;
    logic                misalign;
    logic                handshake;
    logic                resp_take;
    logic                start_mem;
    logic [RESULT_W-1:0] ex_result;
    logic [RESULT_W-1:0] load_data;

    assign ex_ready  = (state == IDLE);
    assign accept    = ex_valid & (state == IDLE) & ~flush;
    assign is_mem    = ex_is_load | ex_is_store;
    assign misalign  = is_mem & (|(ex_ls_address[2:0] & align_mask(ex_ls_size)));
    assign start_mem = accept & is_mem & ~misalign;
    assign handshake = (state == REQ) & dmem_req_ready;
    assign resp_take = (state == WAIT) & dmem_resp_valid;

    always_comb begin
        ex_result = ex_alu_result;
        if (ex_is_muldiv)
            ex_result = ex_muldiv_result;
        else if (ex_is_bju)
            ex_result = ex_bju_result;
    end

    // Next state and request outputs; request fields come only from the captured
    // op so they cannot move while a request is waiting for ready.
    always_comb begin
        state_next     = state;
        dmem_req_valid = 1'b0;
        dmem_req_wen   = op.is_store;
        dmem_req_addr  = {op.addr[RESULT_W-1:3], 3'b000};
        dmem_req_wdata = op.store_data << {op.addr[2:0], 3'b000};
        dmem_req_wmask = byte_mask(op.ls_size) << op.addr[2:0];
        case (state)
            IDLE: begin
                if (start_mem)
                    state_next = REQ;
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                // A handshake already committed the memory side, so it wins over flush
                if (dmem_req_ready)
                    state_next = WAIT;
                else if (flush)
                    state_next = IDLE;
            end
            WAIT: begin
                if (dmem_resp_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    mem_stage_load_align u_load_align (
        .rdata       (dmem_resp_rdata),
        .offset      (op.addr[2:0]),
        .ls_size     (op.ls_size),
        .is_unsigned (op.is_unsigned),
        .data        (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op          <= '0;
            killed      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_wen      <= 1'b0;
            wb_data     <= '0;
            wb_pc       <= '0;
            wb_instr    <= '0;
            wb_misalign <= 1'b0;
        end else begin
            state    <= state_next;
            wb_valid <= 1'b0;

            if (start_mem) begin
                op.rd          <= ex_rd;
                op.need_to_wb  <= ex_need_to_wb;
                op.is_store    <= ex_is_store;
                op.is_unsigned <= ex_is_unsigned;
                op.ls_size     <= ex_ls_size;
                op.addr        <= ex_ls_address;
                op.store_data  <= ex_store_data;
                op.pc          <= ex_pc;
                op.instr       <= ex_instr;
                killed         <= 1'b0;
            end

            // Once the request is out, a flush only marks the response for discard
            if (flush && (handshake || state == WAIT))
                killed <= 1'b1;

            // Non-memory and misaligned ops retire straight from the accept cycle
            if (accept && !start_mem) begin
                wb_valid    <= 1'b1;
                wb_rd       <= ex_rd;
                wb_wen      <= ex_need_to_wb & ~misalign & ~ex_is_store & (ex_rd != '0);
                wb_data     <= misalign ? ex_ls_address : ex_result;
                wb_pc       <= ex_pc;
                wb_instr    <= ex_instr;
                wb_misalign <= misalign;
            end

            if (resp_take) begin
                wb_valid    <= ~(killed | flush);
                wb_rd       <= op.rd;
                wb_wen      <= op.need_to_wb & ~op.is_store & (op.rd != '0) & ~(killed | flush);
                wb_data     <= op.is_store ? '0 : load_data;
                wb_pc       <= op.pc;
                wb_instr    <= op.instr;
                wb_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops, each
// checked against a transaction-level model of the expected request and writeback.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic                ex_valid, ex_need_to_wb, ex_is_load, ex_is_store;
    logic                ex_is_unsigned, ex_is_bju, ex_is_muldiv, ex_ready, flush;
    logic [LREG_W-1:0]   ex_rd;
    logic [3:0]          ex_ls_size;
    logic [RESULT_W-1:0] ex_ls_address, ex_store_data, ex_alu_result;
    logic [RESULT_W-1:0] ex_bju_result, ex_muldiv_result;
    logic [PC_W-1:0]     ex_pc;
    logic [INSTR_W-1:0]  ex_instr;
    logic                dmem_req_valid, dmem_req_wen, dmem_req_ready, dmem_resp_valid;
    logic [RESULT_W-1:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata;
    logic [7:0]          dmem_req_wmask;
    logic                wb_valid, wb_wen, wb_misalign;
    logic [LREG_W-1:0]   wb_rd;
    logic [RESULT_W-1:0] wb_data;
    logic [PC_W-1:0]     wb_pc;
    logic [INSTR_W-1:0]  wb_instr;

    mem_stage dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_need_to_wb(ex_need_to_wb),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_ls_size(ex_ls_size),
        .ex_is_unsigned(ex_is_unsigned), .ex_is_bju(ex_is_bju), .ex_is_muldiv(ex_is_muldiv),
        .ex_ls_address(ex_ls_address), .ex_store_data(ex_store_data),
        .ex_alu_result(ex_alu_result), .ex_bju_result(ex_bju_result),
        .ex_muldiv_result(ex_muldiv_result), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_ready(ex_ready), .flush(flush),
        .dmem_req_valid(dmem_req_valid), .dmem_req_wen(dmem_req_wen),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_wmask(dmem_req_wmask), .dmem_req_ready(dmem_req_ready),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_misalign(wb_misalign)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        int          kind;   // 0 = non-memory, 1 = load, 2 = store
        logic [4:0]  rd;
        logic        need, uns, bju, muldiv;
        int          nb;     // access size in bytes
        logic [63:0] addr, sdata, alu, bju_r, muldiv_r, pc;
        logic [31:0] instr;
    } tb_op_t;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [3:0] size_code(input int nb);
        case (nb)
            1:       return 4'b0001;
            2:       return 4'b0010;
            4:       return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Reference: pick the nb addressed bytes one by one, then extend
    function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input int nb, input logic uns);
        logic [63:0] v;
        int off;
        v = '0;
        off = int'(addr[2:0]);
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!uns && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] exp_wmask(input logic [63:0] addr, input int nb);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nb; i++) m[int'(addr[2:0]) + i] = 1'b1;
        return m;
    endfunction

    function automatic tb_op_t mk_op(input int kind, input logic [4:0] rd, input int nb,
                                     input logic [63:0] addr, input logic [63:0] sdata,
                                     input logic [63:0] alu, input logic uns);
        tb_op_t o;
        o.kind = kind; o.rd = rd; o.need = (kind != 2); o.uns = uns;
        o.bju = 1'b0; o.muldiv = 1'b0; o.nb = nb; o.addr = addr; o.sdata = sdata;
        o.alu = alu; o.bju_r = rand64(); o.muldiv_r = rand64();
        o.pc = rand64(); o.instr = $urandom;
        return o;
    endfunction

    function automatic tb_op_t rand_op();
        tb_op_t o;
        o = mk_op(int'($urandom_range(0, 2)), 5'($urandom_range(0, 31)),
                  1 << $urandom_range(0, 3), rand64(), rand64(), rand64(), 1'($urandom_range(0, 1)));
        o.need = 1'($urandom_range(0, 3) != 0);
        if (o.kind == 0) begin
            o.bju    = 1'($urandom_range(0, 1));
            o.muldiv = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 1) == 1) o.addr = o.addr & ~64'(o.nb - 1);
        return o;
    endfunction

    task automatic drive_op(input tb_op_t o);
        ex_valid = 1'b1;           ex_rd = o.rd;               ex_need_to_wb = o.need;
        ex_is_load = (o.kind == 1); ex_is_store = (o.kind == 2); ex_ls_size = size_code(o.nb);
        ex_is_unsigned = o.uns;    ex_is_bju = o.bju;          ex_is_muldiv = o.muldiv;
        ex_ls_address = o.addr;    ex_store_data = o.sdata;    ex_alu_result = o.alu;
        ex_bju_result = o.bju_r;   ex_muldiv_result = o.muldiv_r;
        ex_pc = o.pc;              ex_instr = o.instr;
    endtask

    // After accept the EX bus carries junk so only captured values can reach memory/WB
    task automatic scramble_ex();
        ex_valid = 1'b0; ex_rd = 5'($urandom); ex_ls_size = 4'($urandom);
        ex_is_store = 1'($urandom); ex_is_unsigned = 1'($urandom);
        ex_ls_address = rand64(); ex_store_data = rand64(); ex_alu_result = rand64();
        ex_pc = rand64(); ex_instr = $urandom;
    endtask

    task automatic check_req(input string tag, input tb_op_t o);
        check({tag, "_req_valid"}, 64'(dmem_req_valid), 64'(1));
        check({tag, "_req_addr"},  dmem_req_addr, o.addr & ~64'h7);
        check({tag, "_req_wen"},   64'(dmem_req_wen), 64'(o.kind == 2));
        if (o.kind == 2) begin
            check({tag, "_req_wmask"}, 64'(dmem_req_wmask), 64'(exp_wmask(o.addr, o.nb)));
            check({tag, "_req_wdata"}, dmem_req_wdata, o.sdata << (8 * int'(o.addr[2:0])));
        end
    endtask

    // fmode: 0 none, 1 flush in IDLE at issue, 2 flush in REQ before handshake,
    // 3 flush on handshake, 4 flush in WAIT, 5 flush coincident with wb_valid.
    // Entered and left just after a rising edge.
    task automatic run_op(input tb_op_t o, input int k_in, input int rdelay, input int fmode);
        logic        mem, mis, killed, exp_wen;
        logic [63:0] rdata, exp_data;
        int          k;
        mem = (o.kind != 0);
        mis = mem && ((o.addr & 64'(o.nb - 1)) != 0);
        k   = (fmode == 2 && k_in == 0) ? 1 : k_in;
        exp_data = o.muldiv ? o.muldiv_r : (o.bju ? o.bju_r : o.alu);
        exp_wen  = o.need && !mis && (o.kind != 2) && (o.rd != 0);

        drive_op(o);
        flush = (fmode == 1);
        @(negedge clock);
        check("issue_ex_ready", 64'(ex_ready), 64'(1));
        check("issue_no_wb", 64'(wb_valid), 64'(0));
        if (fmode == 1) begin
            @(posedge clock); #1 flush = 1'b0;
            @(negedge clock);
            check("flush_idle_no_wb", 64'(wb_valid), 64'(0));
            check("flush_idle_no_req", 64'(dmem_req_valid), 64'(0));
            check("flush_idle_ready", 64'(ex_ready), 64'(1));
        end
        @(posedge clock); #1 scramble_ex();

        if (!mem || mis) begin
            flush = (fmode == 5);
            @(negedge clock);
            check("direct_wb_valid", 64'(wb_valid), 64'(1));
            check("direct_wb_wen", 64'(wb_wen), 64'(exp_wen));
            check("direct_wb_misalign", 64'(wb_misalign), 64'(mis));
            check("direct_wb_rd", 64'(wb_rd), 64'(o.rd));
            check("direct_wb_pc", wb_pc, o.pc);
            check("direct_no_req", 64'(dmem_req_valid), 64'(0));
            check("direct_ex_ready", 64'(ex_ready), 64'(1));
            if (!mis) check("direct_wb_data", wb_data, exp_data);
            @(posedge clock); #1 flush = 1'b0;
            @(negedge clock);
            check("direct_wb_single", 64'(wb_valid), 64'(0));
            @(posedge clock); #1;
            return;
        end

        for (int i = 0; i < k; i++) begin
            if (fmode == 2 && i == k - 1) flush = 1'b1;
            @(negedge clock);
            check_req("stall", o);
            check("stall_ex_ready", 64'(ex_ready), 64'(0));
            @(posedge clock); #1 flush = 1'b0;
            if (fmode == 2 && i == k - 1) begin
                @(negedge clock);
                check("req_flush_dropped", 64'(dmem_req_valid), 64'(0));
                check("req_flush_no_wb", 64'(wb_valid), 64'(0));
                check("req_flush_ready", 64'(ex_ready), 64'(1));
                @(posedge clock); #1;
                return;
            end
        end

        dmem_req_ready = 1'b1;
        flush = (fmode == 3);
        @(negedge clock);
        check_req("hs", o);
        @(posedge clock); #1 dmem_req_ready = 1'b0; flush = 1'b0;

        for (int i = 0; i < rdelay; i++) begin
            if (fmode == 4 && i == 0) flush = 1'b1;
            @(negedge clock);
            check("wait_no_req", 64'(dmem_req_valid), 64'(0));
            check("wait_ex_ready", 64'(ex_ready), 64'(0));
            check("wait_no_wb", 64'(wb_valid), 64'(0));
            @(posedge clock); #1 flush = 1'b0;
        end

        rdata = rand64();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        if (fmode == 4 && rdelay == 0) flush = 1'b1;
        @(negedge clock);
        check("resp_ex_ready", 64'(ex_ready), 64'(0));
        @(posedge clock); #1 dmem_resp_valid = 1'b0; dmem_resp_rdata = rand64();
        flush  = (fmode == 5);
        killed = (fmode == 3) || (fmode == 4);
        @(negedge clock);
        check("mem_wb_valid", 64'(wb_valid), 64'(!killed));
        check("mem_ex_ready", 64'(ex_ready), 64'(1));
        check("mem_no_req", 64'(dmem_req_valid), 64'(0));
        if (!killed) begin
            check("mem_wb_wen", 64'(wb_wen), 64'(exp_wen));
            check("mem_wb_rd", 64'(wb_rd), 64'(o.rd));
            check("mem_wb_misalign", 64'(wb_misalign), 64'(0));
            check("mem_wb_pc", wb_pc, o.pc);
            check("mem_wb_instr", 64'(wb_instr), 64'(o.instr));
            if (o.kind == 1) check("mem_wb_load", wb_data, exp_load(rdata, o.addr, o.nb, o.uns));
        end
        @(posedge clock); #1 flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_op_t o;
        scramble_ex();
        ex_is_load = 1'b0; ex_need_to_wb = 1'b0; ex_is_bju = 1'b0; ex_is_muldiv = 1'b0;
        ex_bju_result = '0; ex_muldiv_result = '0;
        flush = 1'b0; dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1;   // stale response present across reset
        dmem_resp_rdata = rand64();

        #12;
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_req_valid", 64'(dmem_req_valid), 64'(0));
        check("rst_wb_wen", 64'(wb_wen), 64'(0));
        check("rst_wb_misalign", 64'(wb_misalign), 64'(0));
        check("rst_wb_data", wb_data, 64'(0));
        check("rst_wb_rd", 64'(wb_rd), 64'(0));
        check("rst_wb_pc", wb_pc, 64'(0));
        check("rst_wb_instr", 64'(wb_instr), 64'(0));
        check("rst_ex_ready", 64'(ex_ready), 64'(1));
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("stale_resp_no_wb", 64'(wb_valid), 64'(0));
        check("stale_resp_ready", 64'(ex_ready), 64'(1));
        @(posedge clock); #1 dmem_resp_valid = 1'b0;

        run_op(mk_op(0, 5'd5, 8, 64'h0, 64'h0, 64'h1234, 1'b0), 0, 0, 0);
        run_op(mk_op(1, 5'd3, 1, 64'h1003, 64'h0, 64'h0, 1'b0), 0, 0, 0);
        check("lb_example_model", exp_load(64'h00000000_80000000, 64'h1003, 1, 1'b0),
              64'hFFFF_FFFF_FFFF_FF80);
        run_op(mk_op(2, 5'd9, 2, 64'h2006, 64'hABCD, 64'h0, 1'b0), 0, 1, 0);
        run_op(mk_op(1, 5'd4, 4, 64'h3002, 64'h0, 64'h0, 1'b0), 0, 0, 0);
        run_op(mk_op(1, 5'd6, 8, 64'h4000, 64'h0, 64'h0, 1'b0), 3, 2, 0);
        run_op(mk_op(1, 5'd7, 4, 64'h5004, 64'h0, 64'h0, 1'b1), 1, 2, 4);
        run_op(mk_op(1, 5'd8, 2, 64'h6002, 64'h0, 64'h0, 1'b0), 2, 0, 2);
        run_op(mk_op(2, 5'd1, 8, 64'h7000, rand64(), 64'h0, 1'b0), 0, 1, 3);
        run_op(mk_op(0, 5'd0, 8, 64'h0, 64'h0, 64'hDEAD, 1'b0), 0, 0, 5);

        for (int n = 0; n < 150; n++) begin
            int r;
            o = rand_op();
            r = int'($urandom_range(0, 9));
            run_op(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), (r < 5) ? 0 : r - 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
